// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
//
// Purpose: bundles the operand-beat handshake and the array-edge outputs of
//          systolic_feeder into one interface.
//
// Parameters:
//   N          - array dimension (beats per job, lanes per operand bus)
//   DATA_WIDTH - operand element width
//
// Signals:
//   start        job request (honoured by the feeder only while idle)
//   s_valid      operand beat valid
//   s_ready      feeder accepts a beat (high only while loading)
//   s_a, s_b     operand beat: lane i = A[i][k], lane j = B[k][j], lane 0 in LSBs
//   a_edge       skewed A lanes for array column 0
//   b_edge       skewed B lanes for array row 0
//   pe_enable    array-wide PE enable
//   busy         feeder not idle
//   done         one-cycle job-complete pulse
//   stall_cycles (only with SYSTOLIC_FEEDER_PERF_EN) LOAD cycles without a beat
//
// Modports: master = beat producer / array side, slave = systolic_feeder.
// Optional feature macro: SYSTOLIC_FEEDER_PERF_EN
// ---------------------------------------------------------------------------
interface systolic_feeder_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
);
    logic                    start;
    logic                    s_valid;
    logic                    s_ready;
    logic [N*DATA_WIDTH-1:0] s_a;
    logic [N*DATA_WIDTH-1:0] s_b;
    logic [N*DATA_WIDTH-1:0] a_edge;
    logic [N*DATA_WIDTH-1:0] b_edge;
    logic                    pe_enable;
    logic                    busy;
    logic                    done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0]             stall_cycles;

    modport master (
        output start, s_valid, s_a, s_b,
        input  s_ready, a_edge, b_edge, pe_enable, busy, done, stall_cycles
    );

    modport slave (
        input  start, s_valid, s_a, s_b,
        output s_ready, a_edge, b_edge, pe_enable, busy, done, stall_cycles
    );
`else
    modport master (
        output start, s_valid, s_a, s_b,
        input  s_ready, a_edge, b_edge, pe_enable, busy, done
    );

    modport slave (
        input  start, s_valid, s_a, s_b,
        output s_ready, a_edge, b_edge, pe_enable, busy, done
    );
`endif
endinterface

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Purpose: input skew and sequencing stage in front of an N x N output-
//          stationary systolic multiply array. Beat k carries column k of A
//          and row k of B. Lane i is delayed by i advances so operands meet
//          diagonally in the array; after N beats the lanes are flushed with
//          zeros for 2N-2 advances so every PE finishes and every delay line
//          is left empty for the next job.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of systolic_feeder_if
//            start/s_valid/s_a/s_b in, s_ready/a_edge/b_edge/pe_enable/
//            busy/done out (+ stall_cycles when the perf counter is built)
//
// Job timeline without stalls (cycle 0 = start sampled):
//   LOAD cycles 1..N, FLUSH cycles N+1..3N, zero-injection advances in
//   N+1..3N-2, pe_enable high in 2..3N-1, done in 3N, idle again at 3N+1.
//
// Optional feature macro: SYSTOLIC_FEEDER_PERF_EN adds a saturating 16-bit
// count of LOAD cycles without s_valid (bus.stall_cycles).
// ---------------------------------------------------------------------------
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input logic             clk,
    input logic             rst_n,
    systolic_feeder_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(N + 1);
    localparam int FW = $clog2(2 * N);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [BW-1:0] LAST_BEAT      = BW'(N - 1);
    // Zero-injection advances happen while the flush counter is below this.
    localparam logic [FW-1:0] FLUSH_ADV_END  = FW'(2 * N - 2);
    // Two extra cycles after the last advance: one for the final pe_enable,
    // one for done, so busy covers the done cycle.
    localparam logic [FW-1:0] FLUSH_LAST     = FW'(2 * N - 1);

    logic [1:0]    state_reg;
    logic [BW-1:0] beat_cnt_reg;
    logic [FW-1:0] flush_cnt_reg;
    logic          pe_enable_reg;

    logic          in_idle;
    logic          in_load;
    logic          in_flush;
    logic          accept;
    logic          flush_adv;
    logic          advance;
    logic          job_done;

    logic [N*DW-1:0] inject_a;
    logic [N*DW-1:0] inject_b;
    logic [N*DW-1:0] a_edge_vec;
    logic [N*DW-1:0] b_edge_vec;

    assign in_idle   = (state_reg == ST_IDLE);
    assign in_load   = (state_reg == ST_LOAD);
    assign in_flush  = (state_reg == ST_FLUSH);
    assign accept    = in_load && bus.s_valid;
    assign flush_adv = in_flush && (flush_cnt_reg < FLUSH_ADV_END);
    assign advance   = accept || flush_adv;
    assign job_done  = in_flush && (flush_cnt_reg == FLUSH_LAST);

    // Only a LOAD beat feeds real operands; FLUSH shifts zeros in.
    assign inject_a = in_load ? bus.s_a : '0;
    assign inject_b = in_load ? bus.s_b : '0;

    // -----------------------------------------------------------------------
    // Sequencing FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= ST_LOAD;
                        beat_cnt_reg  <= '0;
                        flush_cnt_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_cnt_reg + BW'(1);
                        if (beat_cnt_reg == LAST_BEAT) begin
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_reg <= flush_cnt_reg + FW'(1);
                    if (job_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The PE consumes the edge registers written by the previous advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_enable_reg <= 1'b0;
        end else begin
            pe_enable_reg <= advance;
        end
    end

    // -----------------------------------------------------------------------
    // Per-lane skew: lane gi has gi delay stages plus one edge register, all
    // frozen when there is no advance.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] a_in;
            logic [DW-1:0] b_in;

            assign a_in = inject_a[gi*DW +: DW];
            assign b_in = inject_b[gi*DW +: DW];

            if (gi == 0) begin : g_direct
                logic [DW-1:0] a_out_reg;
                logic [DW-1:0] b_out_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_out_reg <= '0;
                        b_out_reg <= '0;
                    end else if (advance) begin
                        a_out_reg <= a_in;
                        b_out_reg <= b_in;
                    end
                end

                assign a_edge_vec[gi*DW +: DW] = a_out_reg;
                assign b_edge_vec[gi*DW +: DW] = b_out_reg;
            end else begin : g_delayed
                logic [DW-1:0] a_line_reg [gi];
                logic [DW-1:0] b_line_reg [gi];
                logic [DW-1:0] a_out_reg;
                logic [DW-1:0] b_out_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < gi; d++) begin
                            a_line_reg[d] <= '0;
                            b_line_reg[d] <= '0;
                        end
                        a_out_reg <= '0;
                        b_out_reg <= '0;
                    end else if (advance) begin
                        a_line_reg[0] <= a_in;
                        b_line_reg[0] <= b_in;
                        for (int d = 1; d < gi; d++) begin
                            a_line_reg[d] <= a_line_reg[d-1];
                            b_line_reg[d] <= b_line_reg[d-1];
                        end
                        a_out_reg <= a_line_reg[gi-1];
                        b_out_reg <= b_line_reg[gi-1];
                    end
                end

                assign a_edge_vec[gi*DW +: DW] = a_out_reg;
                assign b_edge_vec[gi*DW +: DW] = b_out_reg;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.s_ready   = in_load;
    assign bus.busy      = !in_idle;
    assign bus.done      = job_done;
    assign bus.pe_enable = pe_enable_reg;
    assign bus.a_edge    = a_edge_vec;
    assign bus.b_edge    = b_edge_vec;

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] stall_cnt_reg;

    // Cleared on the IDLE->LOAD transition so the value survives until the
    // next job starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (in_idle && bus.start) begin
            stall_cnt_reg <= '0;
        end else if (in_load && !bus.s_valid && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_reg;
`endif

endmodule
